chrono_core: RTL
================

# chrono_core

Parametrised stopwatch/countdown timer core with centisecond resolution and a multi-entry lap buffer. It is the counting engine behind the board's watch application, generalised from the single-lap minutes:seconds design. It takes pre-debounced single-cycle button pulses and drives binary time fields and status to a separate display/BCD stage. It has no display multiplexing of its own.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `TICK_HZ`, 100: count resolution. Must divide `CLK_FREQ`. `DIV = CLK_FREQ/TICK_HZ`.
- `LAP_DEPTH`, 4: number of stored laps. Power of two, ≥2.
- `BLINK_CYCLES`, 20_000_000: half-period of the `time_up_led` blink.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `mode`, in, 1: 0 = stopwatch (count up), 1 = timer (count down). Latched into `mode_q` only while in IDLE.
- `start_p`, in, 1: start/resume pulse. Also acknowledges TIME_UP.
- `pause_p`, in, 1: pause pulse.
- `lap_p`, in, 1: capture a lap.
- `clear_p`, in, 1: return to IDLE, zero the time, and empty the lap buffer.
- `load_p`, in, 1: load the preset. Accepted in IDLE only.
- `preset_min`, in, 7: 0–99. Values above 99 clamp to 99.
- `preset_sec`, in, 6: 0–59. Values above 59 clamp to 59.
- `lap_sel`, in, log2(LAP_DEPTH): 0 selects the newest lap.
- `cur_min`, out, 7; `cur_sec`, out, 6; `cur_cs`, out, 7: live time.
- `lap_min`, out, 7; `lap_sec`, out, 6; `lap_cs`, out, 7: selected lap. All zeros if `lap_sel ≥ lap_count`.
- `lap_count`, out, log2(LAP_DEPTH)+1: valid entries, saturating at `LAP_DEPTH`.
- `state`, out, 2: IDLE=0, RUNNING=1, PAUSED=2, TIME_UP=3.
- `wrap_p`, out, 1: one-cycle pulse on stopwatch rollover.
- `time_up_led`, out, 1: blinks while in TIME_UP, otherwise 0.

## Operation
- Reset: every output is 0, the state is IDLE, the lap buffer is empty, the prescaler is 0, and `mode_q` is 0.
- State transitions:
  - IDLE → RUNNING on `start_p`. `mode_q` is latched on the same edge and the prescaler is cleared.
  - RUNNING → PAUSED on `pause_p`.
  - PAUSED → RUNNING on `start_p`.
  - RUNNING → TIME_UP when timer mode reaches 00:00.00.
  - TIME_UP → IDLE on `start_p`. The time stays at zero.
  - Any state → IDLE on `clear_p`.
- Priority for same-cycle pulses: `clear_p` > `start_p`/`pause_p` > `lap_p` > `load_p`. `start_p` and `pause_p` together in RUNNING means pause; in PAUSED it means resume.
- Timer start rule: timer mode started from IDLE at 00:00.00 goes to TIME_UP on the next tick without decrementing.
- Counting: only in RUNNING, one step per prescaler tick.
  - Stopwatch: cs 0–99, then sec 0–59, then min 0–99. 99:59.99 → 00:00.00 pulses `wrap_p` and keeps running.
  - Timer: counts down with borrow. The tick that produces 00:00.00 enters TIME_UP on that same edge. The time never goes below zero.
- Prescaler:
  - Holds its value in PAUSED, so a partial tick is preserved.
  - Cleared in IDLE and TIME_UP.
- `load_p` in IDLE: time = clamped preset, cs = 0. Ignored in any other state.
- Laps:
  - `lap_p` is accepted in RUNNING and PAUSED, either mode.
  - It writes the current time into a circular buffer; the newest entry overwrites the oldest when full.
  - `lap_count` saturates. `lap_sel` indexes relative to the newest entry.
- `mode` changes outside IDLE are ignored until the next IDLE.
- `time_up_led`:
  - Toggles every `BLINK_CYCLES` cycles in TIME_UP, starting at 1 on entry.
  - Forced to 0 in any other state.

## Timing
- Pulse inputs are sampled on the rising edge. The state and time update on that same edge, so outputs are visible 1 cycle after the pulse.
- First tick after a start from IDLE occurs `DIV` cycles after the start edge. Ticks then repeat every `DIV` cycles.
- Lap capture stores the value of `cur_*` before the edge. A lap coincident with a tick stores the pre-tick time.
- The `lap_*` read path is combinational from `lap_sel` through a registered buffer, with zero-cycle latency.
- `wrap_p` is asserted in the cycle after the wrapping edge, for exactly one cycle.
- Reset asserted mid-run returns to reset values immediately (asynchronous). Deassertion takes effect on the next clock edge.

## Structure
- Package `chrono_pkg`: state encoding, `MAX_MIN`=99, `MAX_SEC`=59, `MAX_CS`=99, and the time-record struct {min, sec, cs}.
- Sub-module `tick_prescaler`: parameter `DIV`, inputs `clr`/`en`, output `tick`.
- The lap buffer, FSM, and time counter stay in `chrono_core`.

## Test plan
All scenarios use `CLK_FREQ`=1000, `TICK_HZ`=100 (`DIV`=10), `LAP_DEPTH`=4, `BLINK_CYCLES`=5.
- Stopwatch: `start_p`, run 1000 cycles → `cur_cs`=100 rolled over, i.e. 00:01.00. `pause_p`, wait 500 cycles → unchanged. Resume with prescaler mid-count → next tick arrives after the remaining cycles.
- Timer: `preset_min`=0, `preset_sec`=1, `load_p`, `start_p` → after 100 ticks `state`=TIME_UP, time=00:00.00, `time_up_led` toggles every 5 cycles. `start_p` → IDLE, LED 0.
- Laps: capture 6 laps at distinct times → `lap_count`=4, `lap_sel`=0 is lap 6, `lap_sel`=3 is lap 3. `clear_p` → `lap_count`=0.
- Wrap: force 99:59.99 via a run of the full duration → next tick gives 00:00.00 and one `wrap_p` pulse.
- Collisions:
  - `clear_p`+`start_p` → IDLE.
  - `lap_p` on a tick edge → pre-tick value stored.
  - `load_p` while RUNNING → ignored.
  - `preset_sec`=63 → loads 59.
- Reset: assert `reset` low mid-RUNNING → all outputs 0 asynchronously.

Source files
------------

// File: rtl/chrono_pkg.sv
// chrono_pkg: shared state encoding, time limits and time record for the chrono core
package chrono_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_TIME_UP = 2'd3
    } state_t;

    localparam logic [6:0] MAX_MIN = 7'd99;
    localparam logic [5:0] MAX_SEC = 6'd59;
    localparam logic [6:0] MAX_CS  = 7'd99;

    typedef struct packed {
        logic [6:0] min;
        logic [5:0] sec;
        logic [6:0] cs;
    } chrono_time_t;

    function automatic chrono_time_t preset_time(input logic [6:0] m, input logic [5:0] s);
        chrono_time_t t;
        t.min = (m > MAX_MIN) ? MAX_MIN : m;
        t.sec = (s > MAX_SEC) ? MAX_SEC : s;
        t.cs  = 7'd0;
        return t;
    endfunction
endpackage

// File: rtl/chrono_if.sv
// chrono_if: button pulses, preset and lap select in; live time, lap readout and status out
interface chrono_if #(parameter int LAP_DEPTH = 4);
    import chrono_pkg::*;
    localparam int LAP_W = $clog2(LAP_DEPTH);
    logic             mode;
    logic             start_p;
    logic             pause_p;
    logic             lap_p;
    logic             clear_p;
    logic             load_p;
    logic [6:0]       preset_min;
    logic [5:0]       preset_sec;
    logic [LAP_W-1:0] lap_sel;
    logic [6:0]       cur_min;
    logic [5:0]       cur_sec;
    logic [6:0]       cur_cs;
    logic [6:0]       lap_min;
    logic [5:0]       lap_sec;
    logic [6:0]       lap_cs;
    logic [LAP_W:0]   lap_count;
    state_t           state;
    logic             wrap_p;
    logic             time_up_led;

    modport master (
        output mode, start_p, pause_p, lap_p, clear_p, load_p, preset_min, preset_sec, lap_sel,
        input  cur_min, cur_sec, cur_cs, lap_min, lap_sec, lap_cs, lap_count, state, wrap_p, time_up_led
    );
    modport slave (
        input  mode, start_p, pause_p, lap_p, clear_p, load_p, preset_min, preset_sec, lap_sel,
        output cur_min, cur_sec, cur_cs, lap_min, lap_sec, lap_cs, lap_count, state, wrap_p, time_up_led
    );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every DIV enabled cycles; holds its count while disabled
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    logic [W-1:0] r_cnt;

    assign tick = en && (r_cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/chrono_core.sv
// chrono_core: stopwatch/countdown engine with centisecond steps, circular lap buffer and TIME_UP blink
module chrono_core
    import chrono_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int TICK_HZ      = 100,
    parameter int LAP_DEPTH    = 4,
    parameter int BLINK_CYCLES = 20_000_000
) (
    input logic     clk,
    input logic     reset,
    chrono_if.slave bus
);
    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int LAP_W = $clog2(LAP_DEPTH);
    localparam int BW    = $clog2(BLINK_CYCLES + 1);

    state_t           r_state;
    logic             r_mode_q;
    chrono_time_t     r_cur;
    chrono_time_t     r_laps [LAP_DEPTH];
    logic [LAP_W-1:0] r_wptr;
    logic [LAP_W:0]   r_lap_cnt;
    logic             r_wrap;
    logic             r_led;
    logic [BW-1:0]    r_blink;

    chrono_time_t     w_inc;
    chrono_time_t     w_dec;
    logic             w_zero;
    logic             w_tick;
    logic             w_lap;
    logic [LAP_W-1:0] w_rd_idx;
    logic             w_rd_ok;

    tick_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .reset(reset),
        .clr  (r_state == ST_IDLE || r_state == ST_TIME_UP),
        .en   (r_state == ST_RUNNING),
        .tick (w_tick)
    );

    assign w_zero    = (r_cur == '0);
    assign w_inc.cs  = (r_cur.cs == MAX_CS) ? 7'd0 : r_cur.cs + 7'd1;
    assign w_inc.sec = (r_cur.cs != MAX_CS) ? r_cur.sec : (r_cur.sec == MAX_SEC) ? 6'd0 : r_cur.sec + 6'd1;
    assign w_inc.min = (r_cur.cs != MAX_CS || r_cur.sec != MAX_SEC) ? r_cur.min :
                       (r_cur.min == MAX_MIN) ? 7'd0 : r_cur.min + 7'd1;
    // Countdown saturates at zero so the timer can never underflow
    assign w_dec.cs  = w_zero ? 7'd0 : (r_cur.cs == 7'd0) ? MAX_CS : r_cur.cs - 7'd1;
    assign w_dec.sec = w_zero ? 6'd0 : (r_cur.cs != 7'd0) ? r_cur.sec : (r_cur.sec == 6'd0) ? MAX_SEC : r_cur.sec - 6'd1;
    assign w_dec.min = w_zero ? 7'd0 : (r_cur.cs == 7'd0 && r_cur.sec == 6'd0) ? r_cur.min - 7'd1 : r_cur.min;

    assign w_lap = bus.lap_p && !bus.clear_p && !bus.start_p && !bus.pause_p &&
                   (r_state == ST_RUNNING || r_state == ST_PAUSED);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_mode_q  <= 1'b0;
            r_cur     <= '0;
            r_wptr    <= '0;
            r_lap_cnt <= '0;
            r_wrap    <= 1'b0;
            r_led     <= 1'b0;
            r_blink   <= '0;
        end else begin
            r_wrap <= 1'b0;
            if (bus.clear_p) begin
                r_state   <= ST_IDLE;
                r_cur     <= '0;
                r_wptr    <= '0;
                r_lap_cnt <= '0;
                r_led     <= 1'b0;
                r_blink   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE:
                        if (bus.start_p) begin
                            r_state  <= ST_RUNNING;
                            r_mode_q <= bus.mode;
                        end else if (bus.load_p)
                            r_cur <= preset_time(bus.preset_min, bus.preset_sec);
                    ST_RUNNING: begin
                        if (bus.pause_p)
                            r_state <= ST_PAUSED;
                        if (w_tick && r_mode_q) begin
                            r_cur <= w_dec;
                            if (w_dec == '0) begin
                                r_state <= ST_TIME_UP;
                                r_led   <= 1'b1;
                                r_blink <= '0;
                            end
                        end else if (w_tick) begin
                            r_cur  <= w_inc;
                            r_wrap <= (w_inc == '0);
                        end
                    end
                    ST_PAUSED:
                        if (bus.start_p)
                            r_state <= ST_RUNNING;
                    ST_TIME_UP:
                        if (bus.start_p) begin
                            r_state <= ST_IDLE;
                            r_led   <= 1'b0;
                            r_blink <= '0;
                        end else if (r_blink == BW'(BLINK_CYCLES - 1)) begin
                            r_led   <= !r_led;
                            r_blink <= '0;
                        end else
                            r_blink <= r_blink + 1'b1;
                endcase
                if (w_lap) begin
                    r_wptr <= r_wptr + 1'b1;
                    if (r_lap_cnt != (LAP_W + 1)'(LAP_DEPTH))
                        r_lap_cnt <= r_lap_cnt + 1'b1;
                end
            end
        end

    // Lap storage needs no reset: entries are only visible below r_lap_cnt
    always_ff @(posedge clk)
        if (w_lap)
            r_laps[r_wptr] <= r_cur;

    assign w_rd_idx        = r_wptr - 1'b1 - bus.lap_sel;
    assign w_rd_ok         = {1'b0, bus.lap_sel} < r_lap_cnt;
    assign bus.lap_min     = w_rd_ok ? r_laps[w_rd_idx].min : 7'd0;
    assign bus.lap_sec     = w_rd_ok ? r_laps[w_rd_idx].sec : 6'd0;
    assign bus.lap_cs      = w_rd_ok ? r_laps[w_rd_idx].cs : 7'd0;
    assign bus.cur_min     = r_cur.min;
    assign bus.cur_sec     = r_cur.sec;
    assign bus.cur_cs      = r_cur.cs;
    assign bus.lap_count   = r_lap_cnt;
    assign bus.state       = r_state;
    assign bus.wrap_p      = r_wrap;
    assign bus.time_up_led = r_led;
endmodule
